// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter and data mux for one crossbar master port.
// The grant is held for a whole packet, and beats pass through with zero latency.
module stream_rr_arbiter #(
    parameter int unsigned T_DATA_WIDTH  = 8,
    parameter int unsigned S_DATA_COUNT  = 2,
    parameter int unsigned T_ID___WIDTH  = $clog2(S_DATA_COUNT),
    parameter int unsigned PKT_CNT_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    input  logic [S_DATA_COUNT-1:0]              s_req_i,
    output logic [S_DATA_COUNT-1:0]              s_ready_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic [T_ID___WIDTH-1:0]              m_id_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i,
    output logic                                 busy_o,
    output logic [PKT_CNT_WIDTH-1:0]             pkt_cnt_o
);

    localparam int unsigned IW = T_ID___WIDTH;
    localparam int unsigned CW = T_ID___WIDTH + 1;
    localparam logic [IW-1:0] LAST_ID = IW'(S_DATA_COUNT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                   state, state_d;
    logic [IW-1:0]            ptr, ptr_d;
    logic [IW-1:0]            gnt_id, gnt_id_d;
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt, pkt_cnt_d;

    logic          win_found;
    logic [IW-1:0] win_id;
    logic [CW-1:0] cand;
    logic          act_found;
    logic [IW-1:0] act_id;
    logic          accept;

    function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
        return (id == LAST_ID) ? '0 : id + IW'(1);
    endfunction

    // Scan upward from ptr with wrap. The extra bit keeps ptr+i from overflowing before the fold.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < int'(S_DATA_COUNT); i++) begin
            cand = CW'(ptr) + CW'(i);
            if (cand >= CW'(S_DATA_COUNT)) begin
                cand = cand - CW'(S_DATA_COUNT);
            end
            if (!win_found && s_req_i[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        act_found = (state == LOCKED) || win_found;
        act_id    = (state == LOCKED) ? gnt_id : win_id;
    end

    // Master-port mux. The port is forced quiet while reset is held.
    always_comb begin
        s_ready_o = '0;
        m_data_o  = '0;
        m_id_o    = '0;
        m_last_o  = 1'b0;
        m_valid_o = 1'b0;
        for (int k = 0; k < int'(S_DATA_COUNT); k++) begin
            if (rst && act_found && (act_id == IW'(k))) begin
                m_valid_o    = s_req_i[k];
                m_data_o     = s_data_i[k*T_DATA_WIDTH +: T_DATA_WIDTH];
                m_last_o     = s_last_i[k];
                m_id_o       = IW'(k);
                s_ready_o[k] = m_ready_i;
            end
        end
    end

    assign accept = m_valid_o & m_ready_i;

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        gnt_id_d  = gnt_id;
        pkt_cnt_d = pkt_cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (m_last_o) begin
                        ptr_d     = next_id(act_id);
                        pkt_cnt_d = pkt_cnt + PKT_CNT_WIDTH'(1);
                    end else begin
                        state_d  = LOCKED;
                        gnt_id_d = act_id;
                    end
                end
            end
            LOCKED: begin
                if (accept && m_last_o) begin
                    state_d   = IDLE;
                    ptr_d     = next_id(gnt_id);
                    pkt_cnt_d = pkt_cnt + PKT_CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_id  <= '0;
            pkt_cnt <= '0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            gnt_id  <= gnt_id_d;
            pkt_cnt <= pkt_cnt_d;
        end
    end

    assign busy_o    = (state == LOCKED);
    assign pkt_cnt_o = pkt_cnt;

    // Invariants: a single ready at most, and the priority pointer always names a real port.
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(s_ready_o));
    a_ptr_range:    assert property (@(posedge clk) disable iff (!rst) ptr <= LAST_ID);

endmodule
